dvp_16_8bit_tx: RTL and testbench
=================================

# dvp_16_8bit_tx

DVP-style camera stream transmitter: accepts 16-bit RGB565 pixels over a valid/ready handshake and emits a byte-serial 8-bit stream with vsync/href framing, two bytes per pixel, high byte first. It is the transmit counterpart of the camera 8-to-16-bit capture path. It serves as a camera emulator for loopback tests of the capture/UDP chain and as a source for downstream DVP-input blocks. Frame geometry is fixed by parameters, and the stream runs continuously while enabled.

## Interface
- H_ACTIVE, 640: pixels per line; the line carries 2*H_ACTIVE bytes. Must be ≥1, <2048.
- V_ACTIVE, 480: active lines per frame. Must be ≥1, <2048.
- H_BLANK, 144: idle cycles after every active line, including the last. Must be ≥1.
- VSYNC_LEN, 16: cycles with o_vsync high. Must be ≥1.
- V_BACK, 32: cycles between vsync fall and the first href. Must be ≥1.
- V_FRONT, 32: cycles after the last line's H_BLANK before the frame ends. Must be ≥1.
- i_pclk  in  1  byte clock.
- rst_n  in  1  reset, synchronous, active-low.
- i_en  in  1  frame enable; sampled in IDLE and at frame end.
- i_pix_data  in  16  RGB565 pixel {r5,g6,b5}.
- i_pix_valid  in  1  i_pix_data is valid.
- o_pix_ready  out  1  block consumes a pixel at this edge if i_pix_valid.
- o_pdata  out  8  byte stream.
- o_href  out  1  byte-valid, line active.
- o_vsync  out  1  frame sync, active-high.
- o_frame_done  out  1  one-cycle pulse on the last V_FRONT cycle.
- o_underflow  out  1  sticky: a pixel slot found i_pix_valid low.

## Operation
- States: IDLE, VSYNC, VBACK, ACTIVE, HBLANK, VFRONT. A cycle counter (≥12 bits) counts within the state; a line counter (≥11 bits) counts lines.
- IDLE: all outputs low. When i_en=1 is sampled, go to VSYNC.
- VSYNC runs VSYNC_LEN cycles, then VBACK.
- VBACK runs V_BACK cycles, then ACTIVE.
- ACTIVE runs 2*H_ACTIVE cycles with a byte_sel toggle. byte_sel=0 outputs the high byte; byte_sel=1 outputs the low byte.
- HBLANK runs H_BLANK cycles. If the line counter is below V_ACTIVE-1, increment it and go to ACTIVE. Otherwise go to VFRONT.
- VFRONT runs V_FRONT cycles. At its last cycle, pulse o_frame_done. Then go to VSYNC if i_en=1, else IDLE. Back-to-back frames have no gap.
- Deasserting i_en mid-frame does not truncate the frame. The frame completes, then the block returns to IDLE.
- Handshake: o_pix_ready is combinational and high exactly on the cycle before each high-byte output cycle. That is the last VBACK cycle, the last HBLANK cycle of a non-final line, and each ACTIVE low-byte cycle except the line's last.
- On an edge with ready&valid, capture i_pix_data. The high byte goes to o_pdata immediately and the low byte is held for the next cycle.
- On an edge with ready&!valid, output 0x00 for both bytes of that pixel and set o_underflow. Timing never stalls.
- Outside ACTIVE, o_pdata=0x00. i_pix_valid is ignored when o_pix_ready=0.
- o_underflow clears only on reset.
- All outputs except o_pix_ready are registered.
- Reset values: o_pdata=0, o_href=0, o_vsync=0, o_frame_done=0, o_underflow=0, o_pix_ready=0, state IDLE, counters 0.
- Reset mid-frame aborts the frame at the next edge with no partial-frame completion.

## Timing
- o_vsync rises the cycle after the edge that samples i_en=1 in IDLE. It stays high for exactly VSYNC_LEN cycles.
- The first o_href rises V_BACK cycles after o_vsync falls.
- o_href is high for 2*H_ACTIVE consecutive cycles per line and low for H_BLANK cycles between lines.
- Pixel latency: a pixel accepted at edge t has its high byte on o_pdata in cycle t..t+1 and its low byte in cycle t+1..t+2.
- Frame period = VSYNC_LEN + V_BACK + V_ACTIVE*(2*H_ACTIVE + H_BLANK) + V_FRONT cycles. Exactly V_ACTIVE*H_ACTIVE pixels are accepted per frame.
- o_frame_done aligns with the last VFRONT cycle. The next frame's o_vsync rises on the following cycle.

## Test plan
Use small parameters for all scenarios: H_ACTIVE=4, V_ACTIVE=2, H_BLANK=3, VSYNC_LEN=2, V_BACK=2, V_FRONT=2.

- Reset, then i_en=0 for 20 cycles -> all outputs stay 0 and o_pix_ready never rises.
- i_en=1 held, source always valid with pixels 0x1234, 0x5678, … -> o_vsync high 2 cycles, then 2 low cycles. o_pdata on href reads 12 34 56 78 … for 8 bytes per line. Href is low 3 cycles between lines. Exactly 8 pixels are accepted. o_frame_done pulses once; the period is 28 cycles and the next vsync follows immediately.
- Source drops i_pix_valid for the 3rd pixel of line 0 -> those two bytes are 00 00, o_underflow=1 from then until reset, and href/vsync timing is unchanged.
- i_en dropped during line 0 of frame 1 -> frame 1 completes with both lines and o_frame_done. Then IDLE with no further vsync.
- rst_n low for 1 cycle mid-ACTIVE -> the next cycle has all outputs 0 and state IDLE. With i_en=1, a new vsync starts the cycle after reset release.
- Loopback into the 8-to-16 capture block (de=o_href) -> the captured 16-bit words equal the transmitted pixels in order.

Source files
------------

// File: rtl/dvp_16_8bit_tx_if.sv
// Pixel-side valid/ready handshake between an RGB565 source and dvp_16_8bit_tx.
// The source drives data/valid through the master modport; the transmitter answers with ready.
interface dvp_16_8bit_tx_if;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;

  modport master (output pix_data, output pix_valid, input pix_ready);
  modport slave  (input pix_data, input pix_valid, output pix_ready);
endinterface

// File: rtl/dvp_16_8bit_tx.sv
// DVP camera-stream transmitter: 16-bit RGB565 pixels in, byte-serial 8-bit stream out
// with vsync/href framing, high byte first, fixed frame geometry.
module dvp_16_8bit_tx #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int H_BLANK   = 144,
  parameter int VSYNC_LEN = 16,
  parameter int V_BACK    = 32,
  parameter int V_FRONT   = 32
) (
  input  logic               i_pclk,
  input  logic               rst_n,
  input  logic               i_en,
  dvp_16_8bit_tx_if.slave    pix,
  output logic [7:0]         o_pdata,
  output logic               o_href,
  output logic               o_vsync,
  output logic               o_frame_done,
  output logic               o_underflow
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBACK  = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_HBLANK = 3'd4,
    ST_VFRONT = 3'd5
  } state_t;

  localparam logic [11:0] VS_LAST  = 12'(VSYNC_LEN - 1);
  localparam logic [11:0] VB_LAST  = 12'(V_BACK - 1);
  localparam logic [11:0] ACT_LAST = 12'(2 * H_ACTIVE - 1);
  localparam logic [11:0] HB_LAST  = 12'(H_BLANK - 1);
  localparam logic [11:0] VF_LAST  = 12'(V_FRONT - 1);
  localparam logic [10:0] LN_LAST  = 11'(V_ACTIVE - 1);

  state_t      state_r, state_s;
  logic [11:0] cnt_r, cnt_s;
  logic [10:0] line_r, line_s;
  logic [7:0]  lo_byte_r, lo_byte_s;
  logic [7:0]  pdata_s;
  logic        ready_s, take_s, miss_s, byte_sel_s;

  // ACTIVE alternates bytes on the cycle counter's LSB: even = high byte, odd = low byte
  assign byte_sel_s = cnt_r[0];

  // Ready precedes every high-byte cycle: last VBACK, last HBLANK of a non-final line, ACTIVE low bytes
  always_comb begin
    ready_s = 1'b0;
    if (!rst_n) begin
      ready_s = 1'b0;
    end else if (state_r == ST_VBACK) begin
      ready_s = (cnt_r == VB_LAST);
    end else if (state_r == ST_HBLANK) begin
      ready_s = (cnt_r == HB_LAST) && (line_r < LN_LAST);
    end else if (state_r == ST_ACTIVE) begin
      ready_s = byte_sel_s && (cnt_r != ACT_LAST);
    end else begin
      ready_s = 1'b0;
    end
  end

  assign pix.pix_ready = ready_s;
  assign take_s        = ready_s & pix.pix_valid;
  assign miss_s        = ready_s & ~pix.pix_valid;

  // Next-state, counters and next byte; timing never waits on the pixel source
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r + 12'd1;
    line_s    = line_r;
    lo_byte_s = lo_byte_r;
    pdata_s   = 8'h00;
    case (state_r)
      ST_IDLE: begin
        cnt_s  = 12'd0;
        line_s = 11'd0;
        if (i_en) state_s = ST_VSYNC;
        else      state_s = ST_IDLE;
      end
      ST_VSYNC: begin
        if (cnt_r == VS_LAST) begin
          state_s = ST_VBACK;
          cnt_s   = 12'd0;
        end else begin
          state_s = ST_VSYNC;
        end
      end
      ST_VBACK: begin
        if (cnt_r == VB_LAST) begin
          state_s = ST_ACTIVE;
          cnt_s   = 12'd0;
          line_s  = 11'd0;
        end else begin
          state_s = ST_VBACK;
        end
      end
      ST_ACTIVE: begin
        if (cnt_r == ACT_LAST) begin
          state_s = ST_HBLANK;
          cnt_s   = 12'd0;
        end else begin
          state_s = ST_ACTIVE;
        end
      end
      ST_HBLANK: begin
        if (cnt_r == HB_LAST) begin
          cnt_s = 12'd0;
          if (line_r < LN_LAST) begin
            state_s = ST_ACTIVE;
            line_s  = line_r + 11'd1;
          end else begin
            state_s = ST_VFRONT;
          end
        end else begin
          state_s = ST_HBLANK;
        end
      end
      ST_VFRONT: begin
        if (cnt_r == VF_LAST) begin
          cnt_s = 12'd0;
          if (i_en) state_s = ST_VSYNC;
          else      state_s = ST_IDLE;
        end else begin
          state_s = ST_VFRONT;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 12'd0;
        line_s  = 11'd0;
      end
    endcase

    // A missed pixel slot emits zero for both of its bytes
    if (take_s) begin
      lo_byte_s = pix.pix_data[7:0];
    end else if (miss_s) begin
      lo_byte_s = 8'h00;
    end else begin
      lo_byte_s = lo_byte_r;
    end

    if (state_s != ST_ACTIVE) begin
      pdata_s = 8'h00;
    end else if (ready_s) begin
      pdata_s = take_s ? pix.pix_data[15:8] : 8'h00;
    end else begin
      pdata_s = lo_byte_r;
    end
  end

  // State, counters and registered outputs with synchronous active-low reset
  always_ff @(posedge i_pclk) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 12'd0;
      line_r       <= 11'd0;
      lo_byte_r    <= 8'h00;
      o_pdata      <= 8'h00;
      o_href       <= 1'b0;
      o_vsync      <= 1'b0;
      o_frame_done <= 1'b0;
      o_underflow  <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      line_r       <= line_s;
      lo_byte_r    <= lo_byte_s;
      o_pdata      <= pdata_s;
      o_href       <= (state_s == ST_ACTIVE);
      o_vsync      <= (state_s == ST_VSYNC);
      o_frame_done <= (state_s == ST_VFRONT) && (cnt_s == VF_LAST);
      o_underflow  <= o_underflow | miss_s;
    end
  end

endmodule

// File: tb/tb_dvp_16_8bit_tx.sv
// Directed bench for dvp_16_8bit_tx with small geometry: framing waveform, byte stream,
// underflow, enable drop, mid-frame reset and 8-to-16 loopback reassembly.
module tb_dvp_16_8bit_tx;
  localparam int HA = 4, VA = 2, HB = 3, VSL = 2, VB = 2, VF = 2;
  localparam int LINE = 2 * HA + HB;
  localparam int PER  = VSL + VB + VA * LINE + VF;

  logic       i_pclk = 1'b0;
  logic       rst_n  = 1'b0;
  logic       i_en   = 1'b0;
  logic [7:0] o_pdata;
  logic       o_href, o_vsync, o_frame_done, o_underflow;

  dvp_16_8bit_tx_if pix_if ();

  dvp_16_8bit_tx #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
    .VSYNC_LEN(VSL), .V_BACK(VB), .V_FRONT(VF)
  ) dut (
    .i_pclk      (i_pclk),
    .rst_n       (rst_n),
    .i_en        (i_en),
    .pix         (pix_if),
    .o_pdata     (o_pdata),
    .o_href      (o_href),
    .o_vsync     (o_vsync),
    .o_frame_done(o_frame_done),
    .o_underflow (o_underflow)
  );

  always #5 i_pclk = ~i_pclk;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tot_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Expected framing, with k = cycle index from the first vsync cycle of a frame
  function automatic logic exp_href(input int k);
    int t = k - (VSL + VB);
    return (t >= 0) && (t / LINE < VA) && (t % LINE < 2 * HA);
  endfunction

  function automatic logic exp_rdy(input int k);
    int t = k - (VSL + VB);
    int ln, off;
    if (t == -1) return 1'b1;
    if (t < 0) return 1'b0;
    ln  = t / LINE;
    off = t % LINE;
    if (ln >= VA) return 1'b0;
    if (off < 2 * HA) return (off % 2 == 1) && (off != 2 * HA - 1);
    return (off == LINE - 1) && (ln < VA - 1);
  endfunction

  logic [7:0]  exp_b[$];
  logic [15:0] exp_w[$];
  int slot = 0, acc_cnt = 0, drop_slot = 10;
  bit chk_data = 1'b1;

  // Pixel source: 0x1234, 0x5678, ... (+0x4444); slot 10 (3rd pixel, line 0, frame 1) withheld
  initial begin
    pix_if.pix_data  = 16'h1234;
    pix_if.pix_valid = 1'b1;
    forever begin
      @(negedge i_pclk);
      if (pix_if.pix_ready === 1'b1) begin
        pix_if.pix_valid = (slot != drop_slot);
        if (pix_if.pix_valid) begin
          exp_b.push_back(pix_if.pix_data[15:8]);
          exp_b.push_back(pix_if.pix_data[7:0]);
          exp_w.push_back(pix_if.pix_data);
          acc_cnt++;
        end else begin
          exp_b.push_back(8'h00);
          exp_b.push_back(8'h00);
          exp_w.push_back(16'h0000);
        end
        slot++;
        @(posedge i_pclk);
        #1;
        if (pix_if.pix_valid) pix_if.pix_data = pix_if.pix_data + 16'h4444;
      end
    end
  end

  // Byte checker plus a model of the 8-to-16 capture path fed with de=o_href
  initial begin
    logic [7:0]  cap_hi;
    logic [31:0] want;
    bit          cap_phase;
    cap_hi    = 8'h00;
    cap_phase = 1'b0;
    forever begin
      @(negedge i_pclk);
      if (chk_data) begin
        if (o_href) begin
          want = (exp_b.size() > 0) ? 32'(exp_b.pop_front()) : 32'h100;
          chk("pdata", 32'(o_pdata), want);
          if (!cap_phase) begin
            cap_hi = o_pdata;
          end else begin
            want = (exp_w.size() > 0) ? 32'(exp_w.pop_front()) : 32'h10000;
            chk("loopback", 32'({cap_hi, o_pdata}), want);
          end
          cap_phase = ~cap_phase;
        end else begin
          chk("pdata_idle", 32'(o_pdata), 32'h0);
          cap_phase = 1'b0;
        end
      end
    end
  end

  task automatic frame_checks(input int k, input logic uf_exp);
    chk("vsync", 32'(o_vsync), 32'(k < VSL));
    chk("href", 32'(o_href), 32'(exp_href(k)));
    chk("frame_done", 32'(o_frame_done), 32'(k == PER - 1));
    chk("pix_ready", 32'(pix_if.pix_ready), 32'(exp_rdy(k)));
    chk("underflow", 32'(o_underflow), 32'(uf_exp));
  endtask

  initial begin
    int acc0, slot0;
    // Reset state
    @(negedge i_pclk);
    @(negedge i_pclk);
    chk("rst_outputs", 32'({o_pdata, o_href, o_vsync, o_frame_done, o_underflow}), 32'h0);
    chk("rst_ready", 32'(pix_if.pix_ready), 32'h0);
    rst_n = 1'b1;

    // Enable low: nothing moves
    for (int i = 0; i < 20; i++) begin
      @(negedge i_pclk);
      chk("idle_quiet", 32'({o_pdata, o_href, o_vsync, o_frame_done, o_underflow, pix_if.pix_ready}), 32'h0);
    end

    // Frame 0 clean, frame 1 with a missed slot and enable dropped during line 0
    i_en = 1'b1;
    for (int f = 0; f < 2; f++) begin
      acc0  = acc_cnt;
      slot0 = slot;
      for (int k = 0; k < PER; k++) begin
        @(negedge i_pclk);
        // missed slot is the cycle-7 ready, so its zero bytes start at cycle 8
        frame_checks(k, (f == 1) && (k >= 8));
        if (f == 1 && k == 6) i_en = 1'b0;
      end
      chk("accepted", 32'(acc_cnt - acc0), (f == 0) ? 32'd8 : 32'd7);
      chk("slots", 32'(slot - slot0), 32'd8);
    end

    // Back in IDLE: no further vsync, underflow remains sticky
    for (int i = 0; i < 10; i++) begin
      @(negedge i_pclk);
      chk("post_idle", 32'({o_href, o_vsync, o_frame_done, pix_if.pix_ready}), 32'h0);
      chk("underflow_sticky", 32'(o_underflow), 32'h1);
    end

    // Reset pulse in the middle of ACTIVE
    i_en = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge i_pclk);
      chk("vsync_pre_rst", 32'(o_vsync), 32'(k < VSL));
      chk("href_pre_rst", 32'(o_href), 32'(exp_href(k)));
    end
    rst_n    = 1'b0;
    chk_data = 1'b0;
    @(negedge i_pclk);
    chk("midrst_outputs", 32'({o_pdata, o_href, o_vsync, o_frame_done, o_underflow}), 32'h0);
    chk("midrst_ready", 32'(pix_if.pix_ready), 32'h0);
    rst_n = 1'b1;
    exp_b.delete();
    exp_w.delete();
    chk_data = 1'b1;

    // Fresh frame right after release, underflow cleared
    acc0  = acc_cnt;
    slot0 = slot;
    for (int k = 0; k < PER; k++) begin
      @(negedge i_pclk);
      frame_checks(k, 1'b0);
    end
    chk("accepted_f2", 32'(acc_cnt - acc0), 32'd8);
    @(negedge i_pclk);
    chk("b2b_vsync", 32'(o_vsync), 32'h1);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
